// File: rtl/wakeup_delay_scheduler_pkg.sv
// Shared widths, slot record and latency helper for the wakeup delay scheduler.
// Optional feature macro: WAKEUP_BYPASS_EN (latency-1 issues go straight to the output register).
package wakeup_delay_scheduler_pkg;

    localparam int ISSUE_W   = 4;
    localparam int WAKE_W    = 7;
    localparam int NUM_SLOTS = 16;
    localparam int PREG_W    = 7;
    localparam int LAT_W     = 3;

    // Channel cursor counts 0..WAKE_W, so it needs one bit more than a channel index.
    localparam int CH_IDX_W  = $clog2(WAKE_W);
    localparam int CH_W      = CH_IDX_W + 1;
    // Occupancy counter counts 0..NUM_SLOTS.
    localparam int OCC_W     = $clog2(NUM_SLOTS + 1);

    localparam logic [LAT_W-1:0] LAT_ONE   = {{(LAT_W-1){1'b0}}, 1'b1};
    localparam logic [LAT_W-1:0] LAT_TWO   = {{(LAT_W-2){1'b0}}, 2'b10};
    localparam logic [CH_W-1:0]  CH_ONE    = {{(CH_W-1){1'b0}}, 1'b1};
    localparam logic [CH_W-1:0]  WAKE_LIM  = CH_W'(WAKE_W);
    localparam logic [OCC_W-1:0] OCC_ONE   = {{(OCC_W-1){1'b0}}, 1'b1};
    localparam logic [OCC_W-1:0] OCC_SLOTS = OCC_W'(NUM_SLOTS);
    localparam logic [OCC_W-1:0] OCC_ISSUE = OCC_W'(ISSUE_W);

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] addr;
        logic [LAT_W-1:0]  cnt;
    } slot_t;

    // A latency of zero is treated as a single-cycle operation.
    function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] lat);
        logic [LAT_W-1:0] res;
        if (lat == {LAT_W{1'b0}}) begin
            res = LAT_ONE;
        end else begin
            res = lat;
        end
        return res;
    endfunction

endpackage

// File: rtl/wakeup_delay_scheduler_chk.sv
// Protocol checker: upstream must hold off issuing while the scheduler reports full.
module wakeup_delay_scheduler_chk
    import wakeup_delay_scheduler_pkg::*;
(
    input logic               Clk,
    input logic               Rest,
    input logic               WkFull,
    input logic [ISSUE_W-1:0] IssueAble
);

    no_issue_when_full: assert property (@(posedge Clk) disable iff (Rest)
        WkFull |-> (IssueAble == {ISSUE_W{1'b0}}));

endmodule

// File: rtl/wakeup_slot.sv
// One pending-wakeup entry: holds a destination preg and counts its remaining latency down to zero,
// where it waits until the top selects it for a broadcast channel.
module wakeup_slot
    import wakeup_delay_scheduler_pkg::*;
(
    input  logic              Clk,
    input  logic              Rest,
    input  logic              flush,
    input  logic              load,
    input  logic [PREG_W-1:0] load_addr,
    input  logic [LAT_W-1:0]  load_cnt,
    input  logic              release_en,
    output slot_t             slot
);

    slot_t slot_r;

    // Entry state: clear on reset/flush, load on allocation, free when broadcast, else count down and hold at zero
    always_ff @(posedge Clk) begin
        if (Rest) begin
            slot_r <= '0;
        end else if (flush) begin
            slot_r <= '0;
        end else if (load) begin
            slot_r.valid <= 1'b1;
            slot_r.addr  <= load_addr;
            slot_r.cnt   <= load_cnt;
        end else if (release_en) begin
            slot_r.valid <= 1'b0;
        end else if (slot_r.valid && (slot_r.cnt != {LAT_W{1'b0}})) begin
            slot_r.cnt <= slot_r.cnt - LAT_ONE;
        end else begin
            slot_r <= slot_r;
        end
    end

    assign slot = slot_r;

endmodule

// File: rtl/wakeup_delay_scheduler.sv
// Wakeup delay scheduler: records issued destinations with their latency, counts down, and broadcasts
// the busy-table clears on WAKE_W channels. Optional macro WAKEUP_BYPASS_EN sends latency-1 issues
// directly to the output register ahead of expired slots.
module wakeup_delay_scheduler
    import wakeup_delay_scheduler_pkg::*;
(
    input  logic                       Clk,
    input  logic                       Rest,
    input  logic                       WkFlash,
    input  logic [ISSUE_W-1:0]         IssueAble,
    input  logic [ISSUE_W*PREG_W-1:0]  IssueAddr,
    input  logic [ISSUE_W*LAT_W-1:0]   IssueLat,
    output logic                       WkFull,
    output logic [WAKE_W-1:0]          UnBusyAble,
    output logic [WAKE_W*PREG_W-1:0]   UnBusyAddr
);

    slot_t                 slot_s      [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  load_s;
    logic [NUM_SLOTS-1:0]  release_s;
    logic [PREG_W-1:0]     load_addr_s [NUM_SLOTS];
    logic [LAT_W-1:0]      load_cnt_s  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  avail_s;
    logic                  port_done_s;
    logic [LAT_W-1:0]      lat_s       [ISSUE_W];
    logic [ISSUE_W-1:0]    byp_s;
    logic [CH_W-1:0]       ch_s;
    logic [WAKE_W-1:0]     able_nxt_s;
    logic [PREG_W-1:0]     addr_nxt_s  [WAKE_W];
    logic [WAKE_W*PREG_W-1:0] addr_pack_s;
    logic [OCC_W-1:0]      occ_nxt_s;
    logic                  full_nxt_s;

    logic                  full_r;
    logic [WAKE_W-1:0]     able_r;
    logic [WAKE_W*PREG_W-1:0] addr_r;

    for (genvar j = 0; j < NUM_SLOTS; j++) begin : g_slot
        wakeup_slot u_slot (
            .Clk        (Clk),
            .Rest       (Rest),
            .flush      (WkFlash),
            .load       (load_s[j]),
            .load_addr  (load_addr_s[j]),
            .load_cnt   (load_cnt_s[j]),
            .release_en (release_s[j]),
            .slot       (slot_s[j])
        );
    end

    wakeup_delay_scheduler_chk u_chk (
        .Clk       (Clk),
        .Rest      (Rest),
        .WkFull    (full_r),
        .IssueAble (IssueAble)
    );

    // Normalise each port's latency and decide which issues bypass the slot table
    always_comb begin
        for (int p = 0; p < ISSUE_W; p++) begin
            lat_s[p] = eff_lat(IssueLat[p*LAT_W +: LAT_W]);
`ifdef WAKEUP_BYPASS_EN
            byp_s[p] = IssueAble[p] && (lat_s[p] == LAT_ONE);
`else
            byp_s[p] = 1'b0;
`endif
        end
    end

    // Allocation: active ports in ascending order claim the lowest slots that are free before this edge
    always_comb begin
        load_s      = {NUM_SLOTS{1'b0}};
        port_done_s = 1'b0;
        for (int j = 0; j < NUM_SLOTS; j++) begin
            avail_s[j]     = ~slot_s[j].valid;
            load_addr_s[j] = {PREG_W{1'b0}};
            load_cnt_s[j]  = {LAT_W{1'b0}};
        end
        for (int p = 0; p < ISSUE_W; p++) begin
            port_done_s = 1'b0;
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (IssueAble[p] && !byp_s[p] && !port_done_s && avail_s[j]) begin
                    load_s[j]      = 1'b1;
                    load_addr_s[j] = IssueAddr[p*PREG_W +: PREG_W];
`ifdef WAKEUP_BYPASS_EN
                    load_cnt_s[j]  = lat_s[p] - LAT_TWO;
`else
                    load_cnt_s[j]  = lat_s[p] - LAT_ONE;
`endif
                    avail_s[j]     = 1'b0;
                    port_done_s    = 1'b1;
                end else begin
                    port_done_s    = port_done_s;
                end
            end
        end
    end

    // Channel selection: bypass issues first, then expired slots in ascending slot order until channels run out
    always_comb begin
        ch_s       = {CH_W{1'b0}};
        able_nxt_s = {WAKE_W{1'b0}};
        release_s  = {NUM_SLOTS{1'b0}};
        for (int k = 0; k < WAKE_W; k++) begin
            addr_nxt_s[k] = {PREG_W{1'b0}};
        end
        for (int p = 0; p < ISSUE_W; p++) begin
            if (byp_s[p] && (ch_s < WAKE_LIM)) begin
                able_nxt_s[ch_s[CH_IDX_W-1:0]] = 1'b1;
                addr_nxt_s[ch_s[CH_IDX_W-1:0]] = IssueAddr[p*PREG_W +: PREG_W];
                ch_s = ch_s + CH_ONE;
            end else begin
                ch_s = ch_s;
            end
        end
        for (int j = 0; j < NUM_SLOTS; j++) begin
            if (slot_s[j].valid && (slot_s[j].cnt == {LAT_W{1'b0}}) && (ch_s < WAKE_LIM)) begin
                release_s[j] = 1'b1;
                able_nxt_s[ch_s[CH_IDX_W-1:0]] = 1'b1;
                addr_nxt_s[ch_s[CH_IDX_W-1:0]] = slot_s[j].addr;
                ch_s = ch_s + CH_ONE;
            end else begin
                ch_s = ch_s;
            end
        end
        for (int k = 0; k < WAKE_W; k++) begin
            addr_pack_s[k*PREG_W +: PREG_W] = addr_nxt_s[k];
        end
    end

    // Occupancy after this edge's frees and allocations; full when fewer than ISSUE_W slots would remain
    always_comb begin
        occ_nxt_s = {OCC_W{1'b0}};
        for (int j = 0; j < NUM_SLOTS; j++) begin
            if ((slot_s[j].valid && !release_s[j]) || load_s[j]) begin
                occ_nxt_s = occ_nxt_s + OCC_ONE;
            end else begin
                occ_nxt_s = occ_nxt_s;
            end
        end
        full_nxt_s = ((OCC_SLOTS - occ_nxt_s) < OCC_ISSUE);
    end

    // Registered broadcast and full flag; flush empties everything so nothing remains pending
    always_ff @(posedge Clk) begin
        if (Rest) begin
            able_r <= {WAKE_W{1'b0}};
            addr_r <= {(WAKE_W*PREG_W){1'b0}};
            full_r <= 1'b0;
        end else if (WkFlash) begin
            able_r <= {WAKE_W{1'b0}};
            addr_r <= {(WAKE_W*PREG_W){1'b0}};
            full_r <= 1'b0;
        end else begin
            able_r <= able_nxt_s;
            addr_r <= addr_pack_s;
            full_r <= full_nxt_s;
        end
    end

    assign WkFull     = full_r;
    assign UnBusyAble = able_r;
    assign UnBusyAddr = addr_r;

endmodule

// File: tb/tb_wakeup_delay_scheduler.sv
// Directed self-checking bench for wakeup_delay_scheduler; expected timings account for WAKEUP_BYPASS_EN.
module tb_wakeup_delay_scheduler;
    import wakeup_delay_scheduler_pkg::*;

`ifdef WAKEUP_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic                      Clk = 1'b0;
    logic                      Rest;
    logic                      WkFlash;
    logic [ISSUE_W-1:0]        IssueAble;
    logic [ISSUE_W*PREG_W-1:0] IssueAddr;
    logic [ISSUE_W*LAT_W-1:0]  IssueLat;
    logic                      WkFull;
    logic [WAKE_W-1:0]         UnBusyAble;
    logic [WAKE_W*PREG_W-1:0]  UnBusyAddr;

    int errors = 0;
    int checks = 0;

    wakeup_delay_scheduler dut (
        .Clk        (Clk),
        .Rest       (Rest),
        .WkFlash    (WkFlash),
        .IssueAble  (IssueAble),
        .IssueAddr  (IssueAddr),
        .IssueLat   (IssueLat),
        .WkFull     (WkFull),
        .UnBusyAble (UnBusyAble),
        .UnBusyAddr (UnBusyAddr)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_in();
        IssueAble = '0;
        IssueAddr = '0;
        IssueLat  = '0;
        WkFlash   = 1'b0;
    endtask

    task automatic set_port(input int p, input int a, input int l);
        IssueAble[p] = 1'b1;
        IssueAddr[p*PREG_W +: PREG_W] = PREG_W'(a);
        IssueLat[p*LAT_W +: LAT_W]    = LAT_W'(l);
    endtask

    // Reset state, then a single L=3 issue on port 0
    task automatic test_reset();
        logic [WAKE_W*PREG_W-1:0] exp_addr;
        int k;
        k = 4 - BYP;
        Rest = 1'b1;
        clear_in();
        step();
        step();
        checks++;
        if (UnBusyAble !== 7'b0 || UnBusyAddr !== '0 || WkFull !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: able=%b addr=%h full=%b, required all zero", UnBusyAble, UnBusyAddr, WkFull);
        end
        Rest = 1'b0;
        set_port(0, 5, 3);
        step();
        clear_in();
        for (int c = 1; c < k; c++) begin
            checks++;
            if (UnBusyAble !== 7'b0) begin
                errors++;
                $display("FAIL single_early c=%0d: able=%b, required 0000000", c, UnBusyAble);
            end
            step();
        end
        exp_addr = '0;
        exp_addr[0 +: PREG_W] = 7'd5;
        checks++;
        if (UnBusyAble !== 7'b0000001 || UnBusyAddr !== exp_addr) begin
            errors++;
            $display("FAIL single_wake: able=%b addr=%h, required 0000001 %h", UnBusyAble, UnBusyAddr, exp_addr);
        end
        step();
        checks++;
        if (UnBusyAble !== 7'b0) begin
            errors++;
            $display("FAIL single_after: able=%b, required 0000000", UnBusyAble);
        end
    endtask

    // Four ports with L=1 land on channels 0..3 in the same cycle
    task automatic test_four_port();
        logic [WAKE_W*PREG_W-1:0] exp_addr;
        int k;
        k = 2 - BYP;
        for (int p = 0; p < 4; p++) set_port(p, 10 + p, 1);
        step();
        clear_in();
        for (int c = 1; c < k; c++) begin
            checks++;
            if (UnBusyAble !== 7'b0) begin
                errors++;
                $display("FAIL four_early: able=%b, required 0000000", UnBusyAble);
            end
            step();
        end
        exp_addr = '0;
        for (int p = 0; p < 4; p++) exp_addr[p*PREG_W +: PREG_W] = PREG_W'(10 + p);
        checks++;
        if (UnBusyAble !== 7'b0001111 || UnBusyAddr !== exp_addr) begin
            errors++;
            $display("FAIL four_wake: able=%b addr=%h, required 0001111 %h", UnBusyAble, UnBusyAddr, exp_addr);
        end
        step();
        checks++;
        if (UnBusyAble !== 7'b0) begin
            errors++;
            $display("FAIL four_after: able=%b, required 0000000", UnBusyAble);
        end
    endtask

    // Nine slots converge on one cycle: seven go out, the remaining two follow next cycle
    task automatic test_oversubscribe();
        logic [WAKE_W-1:0]        exp_able;
        logic [WAKE_W*PREG_W-1:0] exp_addr;
        int t;
        t = 8 - BYP;
        for (int c = 0; c < 12; c++) begin
            clear_in();
            if (c == 0) begin
                for (int p = 0; p < 4; p++) set_port(p, 40 + p, 7);
            end else if (c == 1) begin
                for (int p = 0; p < 4; p++) set_port(p, 44 + p, 6);
            end else if (c == 2) begin
                set_port(0, 48, 5);
            end
            exp_able = '0;
            exp_addr = '0;
            if (c == t) begin
                exp_able = 7'b1111111;
                for (int k = 0; k < WAKE_W; k++) exp_addr[k*PREG_W +: PREG_W] = PREG_W'(40 + k);
            end else if (c == t + 1) begin
                exp_able = 7'b0000011;
                exp_addr[0 +: PREG_W]      = 7'd47;
                exp_addr[PREG_W +: PREG_W] = 7'd48;
            end
            if (c >= 3) begin
                checks++;
                if (UnBusyAble !== exp_able || UnBusyAddr !== exp_addr) begin
                    errors++;
                    $display("FAIL oversub c=%0d: able=%b addr=%h, required %b %h", c, UnBusyAble, UnBusyAddr, exp_able, exp_addr);
                end
            end
            step();
        end
        clear_in();
    endtask

    // Fill to 14 slots, then watch WkFull as the two early entries expire one at a time
    task automatic test_full();
        logic exp_full;
        logic [WAKE_W*PREG_W-1:0] exp_addr;
        exp_addr = '0;
        exp_addr[0 +: PREG_W] = 7'd60;
        for (int c = 0; c < 16; c++) begin
            clear_in();
            if (c == 0) begin
                set_port(0, 60, 4);
                set_port(1, 61, 5);
                set_port(2, 62, 7);
                set_port(3, 63, 7);
            end else if (c == 1) begin
                for (int p = 0; p < 4; p++) set_port(p, 64 + p, 7);
            end else if (c == 2) begin
                for (int p = 0; p < 4; p++) set_port(p, 68 + p, 7);
            end else if (c == 3) begin
                set_port(0, 72, 7);
                set_port(1, 73, 7);
            end
            if (c >= 3 && c <= 6) begin
                if (c == 4) exp_full = 1'b1;
                else if (c == 5) exp_full = (BYP == 0) ? 1'b1 : 1'b0;
                else exp_full = 1'b0;
                checks++;
                if (WkFull !== exp_full) begin
                    errors++;
                    $display("FAIL full c=%0d: WkFull=%b, required %b", c, WkFull, exp_full);
                end
            end
            if (c == 5 - BYP) begin
                checks++;
                if (UnBusyAble !== 7'b0000001 || UnBusyAddr !== exp_addr) begin
                    errors++;
                    $display("FAIL full_first_wake: able=%b addr=%h, required 0000001 %h", UnBusyAble, UnBusyAddr, exp_addr);
                end
            end
            step();
        end
        clear_in();
    endtask

    // Flush with six pending plus a same-cycle issue: nothing is ever broadcast
    task automatic test_flush();
        for (int c = 0; c < 16; c++) begin
            clear_in();
            if (c == 0) begin
                for (int p = 0; p < 4; p++) set_port(p, 80 + p, 7);
            end else if (c == 1) begin
                set_port(0, 84, 7);
                set_port(1, 85, 7);
            end else if (c == 2) begin
                WkFlash = 1'b1;
                set_port(0, 20, 1);
            end
            if (c == 3) begin
                checks++;
                if (WkFull !== 1'b0 || UnBusyAddr !== '0) begin
                    errors++;
                    $display("FAIL flush_state: full=%b addr=%h, required 0 0", WkFull, UnBusyAddr);
                end
            end
            if (c >= 3) begin
                checks++;
                if (UnBusyAble !== 7'b0) begin
                    errors++;
                    $display("FAIL flush_quiet c=%0d: able=%b addr=%h, required 0000000", c, UnBusyAble, UnBusyAddr);
                end
            end
            step();
        end
        clear_in();
    endtask

    // Latency 0 behaves like 1; reset during a countdown suppresses the wakeup
    task automatic test_lat0_and_reset();
        logic [WAKE_W-1:0]        exp_able;
        logic [WAKE_W*PREG_W-1:0] exp_addr;
        for (int c = 0; c < 5; c++) begin
            clear_in();
            if (c == 0) set_port(2, 33, 0);
            exp_able = '0;
            exp_addr = '0;
            if (c == 2 - BYP) begin
                exp_able = 7'b0000001;
                exp_addr[0 +: PREG_W] = 7'd33;
            end
            if (c >= 1) begin
                checks++;
                if (UnBusyAble !== exp_able || UnBusyAddr !== exp_addr) begin
                    errors++;
                    $display("FAIL lat0 c=%0d: able=%b addr=%h, required %b %h", c, UnBusyAble, UnBusyAddr, exp_able, exp_addr);
                end
            end
            step();
        end
        for (int c = 0; c < 16; c++) begin
            clear_in();
            Rest = (c == 3) ? 1'b1 : 1'b0;
            if (c == 0) set_port(0, 50, 7);
            if (c == 4) begin
                checks++;
                if (WkFull !== 1'b0 || UnBusyAddr !== '0) begin
                    errors++;
                    $display("FAIL midreset_state: full=%b addr=%h, required 0 0", WkFull, UnBusyAddr);
                end
            end
            if (c >= 4) begin
                checks++;
                if (UnBusyAble !== 7'b0) begin
                    errors++;
                    $display("FAIL midreset_quiet c=%0d: able=%b addr=%h, required 0000000", c, UnBusyAble, UnBusyAddr);
                end
            end
            step();
        end
        Rest = 1'b0;
        clear_in();
    endtask

    initial begin
        test_reset();
        test_four_port();
        test_oversubscribe();
        test_full();
        test_flush();
        test_lat0_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "time limit");
    end

endmodule
